sha_mem_arbiter: RTL and testbench

//  Shares the single bitcoin-hash memory port among NUM_REQ parallel simplified_sha256 cores.

---
 rtl/sha_arb_pkg.sv | 22 ++
 rtl/sha_mem_arbiter_rr_pick.sv | 33 +++
 rtl/sha_mem_arbiter.sv | 166 ++++++++++++++++
 tb/tb_sha_mem_arbiter.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/sha_arb_pkg.sv
// Shared types and default sizes for the sha_mem_arbiter memory-port arbiter.
// The read-return tag index is sized for up to MAX_NUM_REQ cores.
package sha_arb_pkg;

   localparam int DEF_NUM_REQ   = 8;
   localparam int DEF_ADDR_W    = 16;
   localparam int DEF_DATA_W    = 32;
   localparam int DEF_MAX_BURST = 16;
   localparam int MAX_NUM_REQ   = 64;
   localparam int TAG_IDX_W     = $clog2(MAX_NUM_REQ);

   typedef enum logic {
      ARB    = 1'b0,
      LOCKED = 1'b1
   } arb_state_t;

   typedef struct packed {
      logic                 vld;
      logic [TAG_IDX_W-1:0] idx;
   } rd_tag_t;

endpackage

// File: rtl/sha_mem_arbiter_rr_pick.sv
// Combinational round-robin picker: the first asserted request at or above ptr wins,
// and the search wraps from N-1 back to 0.
module rr_pick
   import sha_arb_pkg::*;
#(
   parameter int N = DEF_NUM_REQ,
   parameter int W = $clog2(N)
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] ptr,
   output logic [N-1:0] gnt,
   output logic [W-1:0] idx,
   output logic         any
);

   logic [W-1:0] pos;

   always_comb begin
      gnt = '0;
      idx = '0;
      any = 1'b0;
      pos = '0;
      for (int off = 0; off < N; off++) begin
         pos = W'((int'(ptr) + off) % N);
         if (!any && req[pos]) begin
            any      = 1'b1;
            idx      = pos;
            gnt[pos] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/sha_mem_arbiter.sv
// Shares one hash-memory port among NUM_REQ sha cores: round-robin grant, registered
// command bus, tagged read return. Define SHA_ARB_BURST_EN to enable locked bursts.
module sha_mem_arbiter
   import sha_arb_pkg::*;
#(
   parameter int NUM_REQ   = DEF_NUM_REQ,
   parameter int ADDR_W    = DEF_ADDR_W,
   parameter int DATA_W    = DEF_DATA_W,
   parameter int MAX_BURST = DEF_MAX_BURST
) (
   input  logic                        clk,
   input  logic                        reset_n,
   input  logic [NUM_REQ-1:0]          req,
   input  logic [NUM_REQ-1:0]          req_we,
   input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
   input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
   input  logic [NUM_REQ-1:0]          req_lock,
   output logic [NUM_REQ-1:0]          gnt,
   output logic [NUM_REQ-1:0]          rd_valid,
   output logic [DATA_W-1:0]           rd_data,
   output logic                        busy,
   output logic                        mem_clk,
   output logic                        mem_we,
   output logic [ADDR_W-1:0]           mem_addr,
   output logic [DATA_W-1:0]           mem_write_data,
   input  logic [DATA_W-1:0]           mem_read_data
);

   localparam int WIN_W = $clog2(NUM_REQ);

   logic [WIN_W-1:0]   rr_ptr;
   logic [WIN_W-1:0]   win_idx;
   logic [WIN_W-1:0]   pick_idx;
   logic [NUM_REQ-1:0] pick_gnt;
   logic               pick_any;
   logic               grant;
   logic               cmd_vld;
   rd_tag_t            tag1;
   rd_tag_t            tag2;

   rr_pick #(.N(NUM_REQ), .W(WIN_W)) u_pick (
      .req (req),
      .ptr (rr_ptr),
      .gnt (pick_gnt),
      .idx (pick_idx),
      .any (pick_any)
   );

`ifdef SHA_ARB_BURST_EN
   localparam int CNT_W = $clog2(MAX_BURST + 1);

   arb_state_t       state;
   arb_state_t       state_nxt;
   logic [WIN_W-1:0] lock_idx;
   logic [WIN_W-1:0] lock_idx_nxt;
   logic [WIN_W-1:0] blk_idx;
   logic [WIN_W-1:0] blk_idx_eff;
   logic [CNT_W-1:0] burst_cnt;
   logic [CNT_W-1:0] burst_cnt_nxt;
   logic             blk;
   logic             blk_eff;
   logic             blk_nxt;
   logic             lock_ok;
   logic             exit_max;

   // A burst that hits MAX_BURST falls straight through to round-robin in the same
   // cycle, and its owner may not relock until someone else is served or nobody waits.
   always_comb begin
      lock_ok       = (state == LOCKED) && req[lock_idx] && req_lock[lock_idx] &&
                      (burst_cnt < CNT_W'(MAX_BURST));
      exit_max      = (state == LOCKED) && (burst_cnt >= CNT_W'(MAX_BURST));
      blk_eff       = blk | exit_max;
      blk_idx_eff   = exit_max ? lock_idx : blk_idx;
      state_nxt     = ARB;
      lock_idx_nxt  = lock_idx;
      burst_cnt_nxt = '0;
      blk_nxt       = blk_eff;
      gnt           = pick_gnt;
      win_idx       = pick_idx;
      grant         = pick_any;
      if (lock_ok) begin
         gnt           = '0;
         gnt[lock_idx] = 1'b1;
         win_idx       = lock_idx;
         grant         = 1'b1;
         state_nxt     = LOCKED;
         burst_cnt_nxt = burst_cnt + 1'b1;
      end else begin
         if ((pick_any && (pick_idx != blk_idx_eff)) || (req == '0))
            blk_nxt = 1'b0;
         if (pick_any && req_lock[pick_idx] && !(blk_eff && (pick_idx == blk_idx_eff))) begin
            state_nxt     = LOCKED;
            lock_idx_nxt  = pick_idx;
            burst_cnt_nxt = CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= ARB;
         lock_idx  <= '0;
         burst_cnt <= '0;
         blk       <= 1'b0;
         blk_idx   <= '0;
      end else begin
         state     <= state_nxt;
         lock_idx  <= lock_idx_nxt;
         burst_cnt <= burst_cnt_nxt;
         blk       <= blk_nxt;
         blk_idx   <= blk_idx_eff;
      end
   end
`else
   localparam int unused_max_burst = MAX_BURST;
   logic unused_lock;

   assign unused_lock = ^req_lock;

   always_comb begin
      gnt     = pick_gnt;
      win_idx = pick_idx;
      grant   = pick_any;
   end
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         rr_ptr <= '0;
      else if (grant)
         rr_ptr <= (win_idx == WIN_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
   end

   // Stage 1 drives the memory bus; stage 2 lines the read tag up with mem_read_data.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cmd_vld        <= 1'b0;
         mem_we         <= 1'b0;
         mem_addr       <= '0;
         mem_write_data <= '0;
         tag1           <= '0;
         tag2           <= '0;
      end else begin
         cmd_vld  <= grant;
         mem_we   <= grant & req_we[win_idx];
         tag1.vld <= grant & ~req_we[win_idx];
         tag1.idx <= TAG_IDX_W'(win_idx);
         tag2     <= tag1;
         if (grant) begin
            mem_addr       <= req_addr[win_idx*ADDR_W +: ADDR_W];
            mem_write_data <= req_wdata[win_idx*DATA_W +: DATA_W];
         end
      end
   end

   always_comb begin
      rd_valid = '0;
      for (int i = 0; i < NUM_REQ; i++)
         rd_valid[i] = tag2.vld && (tag2.idx == TAG_IDX_W'(i));
   end

   assign rd_data = tag2.vld ? mem_read_data : '0;
   assign busy    = cmd_vld | tag2.vld;
   assign mem_clk = clk;

endmodule

// File: tb/tb_sha_mem_arbiter.sv
// Directed bench for sha_mem_arbiter with a synchronous one-cycle-latency memory model.
// The locked-burst step runs only when SHA_ARB_BURST_EN is defined.
module tb_sha_mem_arbiter;

   localparam int N  = 8;
   localparam int AW = 16;
   localparam int DW = 32;

   logic            clk = 1'b0;
   logic            reset_n;
   logic [N-1:0]    req;
   logic [N-1:0]    req_we;
   logic [N*AW-1:0] req_addr;
   logic [N*DW-1:0] req_wdata;
   logic [N-1:0]    req_lock;
   logic [N-1:0]    gnt;
   logic [N-1:0]    rd_valid;
   logic [DW-1:0]   rd_data;
   logic            busy;
   logic            mem_clk;
   logic            mem_we;
   logic [AW-1:0]   mem_addr;
   logic [DW-1:0]   mem_write_data;
   logic [DW-1:0]   mem_read_data = '0;

   logic [DW-1:0]   mem     [0:255];
   logic            wr_flag [0:255];

   int total = 0;
   int bad   = 0;

   sha_mem_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .MAX_BURST(16)) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .req            (req),
      .req_we         (req_we),
      .req_addr       (req_addr),
      .req_wdata      (req_wdata),
      .req_lock       (req_lock),
      .gnt            (gnt),
      .rd_valid       (rd_valid),
      .rd_data        (rd_data),
      .busy           (busy),
      .mem_clk        (mem_clk),
      .mem_we         (mem_we),
      .mem_addr       (mem_addr),
      .mem_write_data (mem_write_data),
      .mem_read_data  (mem_read_data)
   );

   always #5 clk = ~clk;

   // Unwritten locations read as a fixed pattern: 0x10 holds DEADBEEF, others A00000xx.
   function automatic logic [DW-1:0] init_val(input logic [7:0] a);
      return (a == 8'h10) ? 32'hDEADBEEF : {24'hA00000, a};
   endfunction

   always @(posedge clk) begin
      if (!reset_n) begin
         for (int i = 0; i < 256; i++) wr_flag[i] <= 1'b0;
      end else if (mem_we) begin
         mem[mem_addr[7:0]]     <= mem_write_data;
         wr_flag[mem_addr[7:0]] <= 1'b1;
      end
      mem_read_data <= wr_flag[mem_addr[7:0]] ? mem[mem_addr[7:0]] : init_val(mem_addr[7:0]);
   end

   task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic apply_stimulus(input logic [N-1:0] r, input logic [N-1:0] we, input logic [N-1:0] lk);
      req      = r;
      req_we   = we;
      req_lock = lk;
   endtask

   task automatic set_core(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
      req_addr[i*AW +: AW]  = a;
      req_wdata[i*DW +: DW] = d;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #3;
   endtask

   task automatic do_reset();
      apply_stimulus('0, '0, '0);
      reset_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
   endtask

   initial begin
      reset_n = 1'b0;
      apply_stimulus('0, '0, '0);
      for (int i = 0; i < N; i++) set_core(i, AW'(16'h0100 + i), '0);

      // Reset values
      do_reset();
      settle();
      check_output("reset_mem_we", mem_we, 0);
      check_output("reset_mem_addr", mem_addr, 0);
      check_output("reset_mem_wdata", mem_write_data, 0);
      check_output("reset_rd_valid", rd_valid, 0);
      check_output("reset_rd_data", rd_data, 0);
      check_output("reset_busy", busy, 0);
      check_output("reset_gnt", gnt, 0);

      // Core 3 reads 0x0010
      tick(); set_core(3, 16'h0010, '0); apply_stimulus(8'h08, '0, '0); settle();
      check_output("t1_gnt", gnt, 8'h08);
      tick(); apply_stimulus('0, '0, '0); settle();
      check_output("t1_mem_addr", mem_addr, 16'h0010);
      check_output("t1_mem_we", mem_we, 0);
      check_output("t1_busy", busy, 1);
      check_output("t1_rd_valid_early", rd_valid, 0);
      tick(); settle();
      check_output("t1_rd_valid", rd_valid, 8'h08);
      check_output("t1_rd_data", rd_data, 32'hDEADBEEF);
      tick(); settle();
      check_output("t1_rd_valid_after", rd_valid, 0);
      check_output("t1_busy_after", busy, 0);

      // All cores read continuously from reset
      do_reset();
      set_core(3, 16'h0103, '0);
      for (int k = 0; k < 16; k++) begin
         tick();
         if (k == 0) apply_stimulus(8'hFF, '0, '0);
         settle();
         check_output($sformatf("t2_gnt_%0d", k), gnt, 64'(1) << (k % 8));
         if (k >= 2) begin
            check_output($sformatf("t2_rd_valid_%0d", k), rd_valid, 64'(1) << ((k - 2) % 8));
            check_output($sformatf("t2_rd_data_%0d", k), rd_data, {24'hA00000, 8'((k - 2) % 8)});
         end else begin
            check_output($sformatf("t2_rd_valid_%0d", k), rd_valid, 0);
         end
      end
      tick(); apply_stimulus('0, '0, '0);
      repeat (3) tick();

      // Core 5 writes 0x0080, core 6 reads it back
      tick(); set_core(5, 16'h0080, 32'h12345678); apply_stimulus(8'h20, 8'h20, '0); settle();
      check_output("t3_gnt5", gnt, 8'h20);
      tick(); set_core(6, 16'h0080, '0); apply_stimulus(8'h40, '0, '0); settle();
      check_output("t3_gnt6", gnt, 8'h40);
      check_output("t3_mem_we_hi", mem_we, 1);
      check_output("t3_mem_addr", mem_addr, 16'h0080);
      check_output("t3_mem_wdata", mem_write_data, 32'h12345678);
      tick(); apply_stimulus('0, '0, '0); settle();
      check_output("t3_mem_we_lo", mem_we, 0);
      check_output("t3_mem_addr_rd", mem_addr, 16'h0080);
      check_output("t3_no_rd_valid_wr", rd_valid, 0);
      tick(); settle();
      check_output("t3_rd_valid6", rd_valid, 8'h40);
      check_output("t3_rd_data", rd_data, 32'h12345678);
      tick(); settle();
      check_output("t3_idle_we", mem_we, 0);
      check_output("t3_idle_addr_hold", mem_addr, 16'h0080);
      check_output("t3_idle_busy", busy, 0);

      // Pointer wrap from 7, then a single requester every cycle
      tick(); apply_stimulus(8'h81, '0, '0); settle();
      check_output("t4_gnt7", gnt, 8'h80);
      tick(); apply_stimulus(8'h01, '0, '0); settle();
      check_output("t4_gnt0", gnt, 8'h01);
      tick(); apply_stimulus(8'h03, '0, '0); settle();
      check_output("t4_ptr1", gnt, 8'h02);
      tick(); apply_stimulus(8'h01, '0, '0); settle();
      check_output("t4_gnt0_again", gnt, 8'h01);
      for (int k = 0; k < 3; k++) begin
         tick(); apply_stimulus(8'h10, '0, '0); settle();
         check_output($sformatf("t4_single_%0d", k), gnt, 8'h10);
      end
      tick(); apply_stimulus('0, '0, '0); settle();
      check_output("t4_gnt_none", gnt, 0);
      repeat (2) tick();

      // Reset pulse while core 2's read is in flight
      tick(); set_core(2, 16'h0010, '0); apply_stimulus(8'h04, '0, '0); settle();
      check_output("t5_gnt2", gnt, 8'h04);
      tick(); apply_stimulus('0, '0, '0);
      reset_n = 1'b0;
      #1;
      check_output("t5_rst_mem_we", mem_we, 0);
      check_output("t5_rst_mem_addr", mem_addr, 0);
      check_output("t5_rst_busy", busy, 0);
      #1 reset_n = 1'b1;
      tick(); settle();
      check_output("t5_no_rd_valid", rd_valid, 0);
      check_output("t5_rd_data", rd_data, 0);
      tick(); apply_stimulus(8'h24, '0, '0); settle();
      check_output("t5_ptr_restart", gnt, 8'h04);
      tick(); apply_stimulus('0, '0, '0);
      repeat (2) tick();

`ifndef SHA_ARB_BURST_EN
      // req_lock has no effect without burst support
      tick(); apply_stimulus(8'h06, '0, 8'h02); settle();
      check_output("t6_nolock_gnt1", gnt, 8'h02);
      tick(); settle();
      check_output("t6_nolock_gnt2", gnt, 8'h04);
      tick(); apply_stimulus('0, '0, '0);
      repeat (2) tick();
`else
      // Core 1 locks for MAX_BURST grants while cores 2 and 4 wait
      do_reset();
      for (int k = 0; k < 16; k++) begin
         tick();
         if (k == 0) apply_stimulus(8'h16, '0, 8'h02);
         settle();
         check_output($sformatf("t6_burst_%0d", k), gnt, 8'h02);
      end
      tick(); settle();
      check_output("t6_after_gnt2", gnt, 8'h04);
      tick(); apply_stimulus(8'h12, '0, 8'h02); settle();
      check_output("t6_after_gnt4", gnt, 8'h10);
      tick(); apply_stimulus('0, '0, '0);
      repeat (2) tick();
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
